// File: rtl/parallell_vektorprodukt.sv
// CH parallel 4-element vector units: element-wise product or 3D cross product,
// two register stages (products, then results) with valid/ready backpressure.
module parallell_vektorprodukt #(
  parameter int W    = 8,
  parameter int CH   = 3,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [CH*4*W-1:0] a_vec,
  input  logic [CH*4*W-1:0] b_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH*4*W-1:0] c_vec,
  output logic [CH-1:0]     ovf,
  output logic              out_mode,
  output logic [CNTW-1:0]   done_cnt
);

  localparam int PW = 2 * W;
  localparam int NP = 6;

  function automatic logic [W-1:0] elem(input logic [CH*4*W-1:0] v, input int k, input int e);
    return v[(k*4+e)*W +: W];
  endfunction

  function automatic logic signed [PW:0] cross_diff(input logic [PW-1:0] pa, input logic [PW-1:0] pb);
    return $signed({1'b0, pa}) - $signed({1'b0, pb});
  endfunction

  function automatic logic [W-1:0] wrap_w(input logic signed [PW:0] d);
    return d[W-1:0];
  endfunction

  function automatic logic range_ovf(input logic signed [PW:0] d);
    return d[PW] | (|d[PW-1:W]);
  endfunction

  logic              s1_adv, s2_adv;
  logic              vld_p1_q;
  logic              mode_p1_q;
  logic [W-1:0]      op_a [CH][NP];
  logic [W-1:0]      op_b [CH][NP];
  logic [PW-1:0]     prod_p1_d [CH][NP];
  logic [PW-1:0]     prod_p1_q [CH][NP];
  logic [CH*4*W-1:0] c_p2_d, c_p2_q;
  logic [CH-1:0]     ovf_p2_d, ovf_p2_q;
  logic              vld_p2_q, mode_p2_q;
  logic [CNTW-1:0]   cnt_q;

  assign s2_adv   = !vld_p2_q || out_ready;
  assign s1_adv   = !vld_p1_q || s2_adv;
  assign in_ready = s1_adv;

  // Cross mode pairs products (0,1),(2,3),(4,5) so each result is p[2e] - p[2e+1].
  always_comb begin
    for (int k = 0; k < CH; k++) begin
      for (int j = 0; j < NP; j++) begin
        op_a[k][j] = '0;
        op_b[k][j] = '0;
      end
      if (in_mode) begin
        op_a[k][0] = elem(a_vec, k, 1); op_b[k][0] = elem(b_vec, k, 2);
        op_a[k][1] = elem(a_vec, k, 2); op_b[k][1] = elem(b_vec, k, 1);
        op_a[k][2] = elem(a_vec, k, 2); op_b[k][2] = elem(b_vec, k, 0);
        op_a[k][3] = elem(a_vec, k, 0); op_b[k][3] = elem(b_vec, k, 2);
        op_a[k][4] = elem(a_vec, k, 0); op_b[k][4] = elem(b_vec, k, 1);
        op_a[k][5] = elem(a_vec, k, 1); op_b[k][5] = elem(b_vec, k, 0);
      end else begin
        for (int e = 0; e < 4; e++) begin
          op_a[k][e] = elem(a_vec, k, e);
          op_b[k][e] = elem(b_vec, k, e);
        end
      end
      for (int j = 0; j < NP; j++) begin
        prod_p1_d[k][j] = PW'(op_a[k][j]) * PW'(op_b[k][j]);
      end
    end
  end

  // ---- stage p1: full-precision products ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
    end else if (s1_adv) begin
      vld_p1_q <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      prod_p1_q <= prod_p1_d;
      mode_p1_q <= in_mode;
    end
  end

  always_comb begin
    c_p2_d   = '0;
    ovf_p2_d = '0;
    for (int k = 0; k < CH; k++) begin
      for (int e = 0; e < 4; e++) begin
        if (mode_p1_q) begin
          if (e < 3) begin
            c_p2_d[(k*4+e)*W +: W] = wrap_w(cross_diff(prod_p1_q[k][2*e], prod_p1_q[k][2*e+1]));
            ovf_p2_d[k] = ovf_p2_d[k] | range_ovf(cross_diff(prod_p1_q[k][2*e], prod_p1_q[k][2*e+1]));
          end
        end else begin
          c_p2_d[(k*4+e)*W +: W] = prod_p1_q[k][e][W-1:0];
          ovf_p2_d[k] = ovf_p2_d[k] | (|prod_p1_q[k][e][PW-1:W]);
        end
      end
    end
  end

  // ---- stage p2: wrapped results, overflow flags, completion counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2_q  <= 1'b0;
      c_p2_q    <= '0;
      ovf_p2_q  <= '0;
      mode_p2_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (s2_adv) begin
        vld_p2_q <= vld_p1_q;
      end
      if (s2_adv && vld_p1_q) begin
        c_p2_q    <= c_p2_d;
        ovf_p2_q  <= ovf_p2_d;
        mode_p2_q <= mode_p1_q;
      end
      if (vld_p2_q && out_ready) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign out_valid = vld_p2_q;
  assign c_vec     = c_p2_q;
  assign ovf       = ovf_p2_q;
  assign out_mode  = mode_p2_q;
  assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_parallell_vektorprodukt.sv
// Bench for parallell_vektorprodukt: random and directed beats against an
// integer-arithmetic model, plus backpressure, mid-flight reset and counter wrap.
module tb_parallell_vektorprodukt;

  localparam int W    = 8;
  localparam int CH   = 3;
  localparam int CNTW = 16;
  localparam int VW   = CH * 4 * W;

  typedef struct packed {
    logic          mode;
    logic [CH-1:0] ovf;
    logic [VW-1:0] c;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_mode = 1'b0;
  logic out_ready = 1'b0;
  logic [VW-1:0] a_vec = '0;
  logic [VW-1:0] b_vec = '0;
  logic in_ready, out_valid, out_mode;
  logic [VW-1:0] c_vec;
  logic [CH-1:0] ovf;
  logic [CNTW-1:0] done_cnt;
  logic in_ready4, out_valid4, out_mode4;
  logic [VW-1:0] c_vec4;
  logic [CH-1:0] ovf4;
  logic [3:0] done_cnt4;

  res_t exp_q[$];
  res_t got_q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  parallell_vektorprodukt #(.W(W), .CH(CH), .CNTW(CNTW)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid), .out_ready(out_ready),
    .c_vec(c_vec), .ovf(ovf), .out_mode(out_mode), .done_cnt(done_cnt));

  parallell_vektorprodukt #(.W(W), .CH(CH), .CNTW(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .in_mode(in_mode),
    .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid4), .out_ready(out_ready),
    .c_vec(c_vec4), .ovf(ovf4), .out_mode(out_mode4), .done_cnt(done_cnt4));

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got_q.push_back({out_mode, ovf, c_vec});
  end

  function automatic res_t model(input logic mode, input logic [VW-1:0] a, input logic [VW-1:0] b);
    res_t r;
    int av[4];
    int bv[4];
    int x[4];
    r.mode = mode;
    r.ovf  = '0;
    r.c    = '0;
    for (int k = 0; k < CH; k++) begin
      for (int e = 0; e < 4; e++) begin
        av[e] = int'(a[(k*4+e)*W +: W]);
        bv[e] = int'(b[(k*4+e)*W +: W]);
      end
      if (!mode) begin
        for (int e = 0; e < 4; e++) x[e] = av[e] * bv[e];
      end else begin
        x[0] = av[1]*bv[2] - av[2]*bv[1];
        x[1] = av[2]*bv[0] - av[0]*bv[2];
        x[2] = av[0]*bv[1] - av[1]*bv[0];
        x[3] = 0;
      end
      for (int e = 0; e < 4; e++) begin
        r.c[(k*4+e)*W +: W] = W'(x[e] & ((1 << W) - 1));
        if (x[e] < 0 || x[e] >= (1 << W)) r.ovf[k] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < CH*4; i++)
      v[i*W +: W] = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 15)) : W'($urandom);
    return v;
  endfunction

  // Presents one beat and returns just after the edge that accepted it.
  task automatic send(input logic mode, input logic [VW-1:0] a, input logic [VW-1:0] b, output bit acc);
    acc = 0;
    in_valid = 1'b1; in_mode = mode; a_vec = a; b_vec = b;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(mode, a, b));
        acc = 1;
      end
      @(posedge clk); #1;
      if (acc) break;
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 0;
    for (int t = 0; t < 200; t++) begin
      if (got_q.size() >= exp_q.size()) begin ok = 1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
    checks++; if (c_vec !== '0) begin errors++; $display("FAIL reset_c_vec got=%h required=0", c_vec); end
    checks++; if (ovf !== '0) begin errors++; $display("FAIL reset_ovf got=%b required=0", ovf); end
    checks++; if (out_mode !== 1'b0) begin errors++; $display("FAIL reset_out_mode got=%b required=0", out_mode); end
    checks++; if (done_cnt !== '0) begin errors++; $display("FAIL reset_done_cnt got=%0d required=0", done_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_elementwise();
    logic [VW-1:0] a, b;
    bit acc, ok;
    out_ready = 1'b1;
    exp_q.delete(); got_q.delete();
    a = rand_vec(); b = rand_vec();
    a[0 +: 32] = {8'd5, 8'd4, 8'd3, 8'd2};
    b[0 +: 32] = {8'd9, 8'd8, 8'd7, 8'd6};
    in_valid = 1'b1; in_mode = 1'b0; a_vec = a; b_vec = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early got=%b required=0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_two got=%b required=1", out_valid); end
    checks++; if (c_vec[0 +: 32] !== {8'd45, 8'd32, 8'd21, 8'd12}) begin errors++; $display("FAIL ew_ch0_c got=%h required=2d20150c", c_vec[0 +: 32]); end
    checks++; if (ovf[0] !== 1'b0) begin errors++; $display("FAIL ew_ch0_ovf got=%b required=0", ovf[0]); end
    @(posedge clk); #1;
    checks++; if (done_cnt !== 16'd1) begin errors++; $display("FAIL ew_done_cnt got=%0d required=1", done_cnt); end
    got_q.delete();
    for (int k = 0; k < CH; k++) begin
      a[k*32 +: 32] = {8'd1, 8'd255, 8'd15, 8'd16};
      b[k*32 +: 32] = {8'd0, 8'd255, 8'd17, 8'd16};
    end
    send(1'b0, a, b, acc);
    for (int i = 0; i < 6; i++) if (acc) send(1'b0, rand_vec(), rand_vec(), acc);
    in_valid = 1'b0;
    checks++; if (!acc) begin errors++; $display("FAIL ew_accept got=0 required=1"); end
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ew_drain got=%0d required=%0d", got_q.size(), exp_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0].c[0 +: 32] !== {8'd0, 8'd1, 8'd255, 8'd0} || got_q[0].ovf !== 3'b111) begin
        errors++; $display("FAIL ew_wrap got=%h/%b required=0001ff00/111", got_q[0].c[0 +: 32], got_q[0].ovf);
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL ew_result[%0d] got=%h required=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_cross();
    logic [VW-1:0] a, b;
    bit acc, ok;
    out_ready = 1'b1;
    a = rand_vec(); b = rand_vec();
    a[32 +: 32] = {8'd7, 8'd0, 8'd0, 8'd1};
    b[32 +: 32] = {8'd9, 8'd0, 8'd1, 8'd0};
    a[64 +: 32] = {8'd0, 8'd0, 8'd1, 8'd0};
    b[64 +: 32] = {8'd0, 8'd0, 8'd0, 8'd1};
    send(1'b1, a, b, acc);
    for (int i = 0; i < 6; i++) if (acc) send(1'b1, rand_vec(), rand_vec(), acc);
    in_valid = 1'b0;
    checks++; if (!acc) begin errors++; $display("FAIL cross_accept got=0 required=1"); end
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL cross_drain got=%0d required=%0d", got_q.size(), exp_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0].c[32 +: 32] !== {8'd0, 8'd1, 8'd0, 8'd0}) begin errors++; $display("FAIL cross_ch1_c got=%h required=00010000", got_q[0].c[32 +: 32]); end
      checks++; if (got_q[0].c[64 +: 32] !== {8'd0, 8'd255, 8'd0, 8'd0}) begin errors++; $display("FAIL cross_ch2_c got=%h required=00ff0000", got_q[0].c[64 +: 32]); end
      checks++; if (got_q[0].ovf[2:1] !== 2'b10 || got_q[0].mode !== 1'b1) begin errors++; $display("FAIL cross_ovf got=%b mode=%b required=10 mode=1", got_q[0].ovf[2:1], got_q[0].mode); end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL cross_result[%0d] got=%h required=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit all_acc;
    res_t held;
    pulse_reset();
    out_ready = 1'b1;
    all_acc = 1;
    fork
      begin
        bit acc;
        for (int i = 0; i < 10; i++) begin
          send(1'(i % 2), rand_vec(), rand_vec(), acc);
          if (!acc) all_acc = 0;
        end
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        held = {out_mode, ovf, c_vec};
        for (int c = 0; c < 5; c++) begin
          checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got=%b required=0", c, in_ready); end
          checks++; if (out_valid !== 1'b1 || {out_mode, ovf, c_vec} !== held) begin
            errors++; $display("FAIL stall_hold[%0d] got=%b/%h required=1/%h", c, out_valid, {out_mode, ovf, c_vec}, held);
          end
          if (c < 4) @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    checks++; if (!all_acc) begin errors++; $display("FAIL b2b_accept got=0 required=1"); end
    wait_drain(ok);
    checks++; if (!ok || got_q.size() != 10) begin errors++; $display("FAIL b2b_count got=%0d required=10", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_result[%0d] got=%h required=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    checks++; if (done_cnt !== 16'd10) begin errors++; $display("FAIL b2b_done_cnt got=%0d required=10", done_cnt); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_midflight();
    bit acc0, acc1;
    logic [VW-1:0] a, b;
    res_t e;
    out_ready = 1'b0;
    send(1'b0, rand_vec(), rand_vec(), acc0);
    send(1'b1, rand_vec(), rand_vec(), acc1);
    in_valid = 1'b0;
    checks++; if (!acc0 || !acc1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_full got=%b%b/%b/%b required=11/0/1", acc0, acc1, in_ready, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%b required=0", out_valid); end
    checks++; if (done_cnt !== '0 || done_cnt4 !== '0) begin errors++; $display("FAIL mid_rst_cnt got=%0d/%0d required=0/0", done_cnt, done_cnt4); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); got_q.delete();
    out_ready = 1'b1;
    @(posedge clk); #1;
    a = rand_vec(); b = rand_vec();
    e = model(1'b1, a, b);
    in_valid = 1'b1; in_mode = 1'b1; a_vec = a; b_vec = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale got=%b required=0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || {out_mode, ovf, c_vec} !== e) begin
      errors++; $display("FAIL mid_first got=%b/%h required=1/%h", out_valid, {out_mode, ovf, c_vec}, e);
    end
    @(posedge clk); #1;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_counter_wrap();
    bit ok;
    bit sent_done;
    bit all_acc;
    pulse_reset();
    out_ready = 1'b1;
    sent_done = 0;
    all_acc = 1;
    fork
      begin
        bit acc;
        for (int i = 0; i < 17; i++) begin
          send(1'($urandom_range(0, 1)), rand_vec(), rand_vec(), acc);
          if (!acc) all_acc = 0;
        end
        in_valid = 1'b0;
        sent_done = 1;
      end
      begin
        while (!sent_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    checks++; if (!all_acc) begin errors++; $display("FAIL wrap_accept got=0 required=1"); end
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_drain got=%0d required=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL wrap_result[%0d] got=%h required=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    checks++; if (done_cnt4 !== 4'd1) begin errors++; $display("FAIL wrap_done_cnt4 got=%0d required=1", done_cnt4); end
    checks++; if (done_cnt !== 16'd17) begin errors++; $display("FAIL wrap_done_cnt got=%0d required=17", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_elementwise();
    test_cross();
    test_back_to_back();
    test_reset_midflight();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
